// File: rtl/csirx_raw_pkg.sv
// Shared definitions for the CSI-2 RX RAW pixel decoder.
// Holds mode encodings, per-mode group sizes, accumulator depth and mode helpers.
// Optional feature macro: RAW_DECODER_RAW12_EN (enables RAW12, deepens accumulator).
package csirx_raw_pkg;

  typedef enum logic [1:0] {
    MODE_RAW8  = 2'b00,
    MODE_RAW10 = 2'b01,
    MODE_RAW12 = 2'b10,
    MODE_RSVD  = 2'b11
  } raw_mode_e;

  localparam int unsigned GRP_RAW8  = 4;
  localparam int unsigned GRP_RAW10 = 5;
  localparam int unsigned GRP_RAW12 = 6;
  localparam int unsigned MAX_GRP   = 6;

`ifdef RAW_DECODER_RAW12_EN
  localparam int unsigned ACC_BYTES = 12;
`else
  localparam int unsigned ACC_BYTES = 8;
`endif

  localparam int unsigned CNT_W = $clog2(ACC_BYTES + 1);

  // Bytes consumed per 4-pixel group.
  function automatic logic [CNT_W-1:0] group_size(input raw_mode_e m);
    case (m)
      MODE_RAW8:  return CNT_W'(GRP_RAW8);
      MODE_RAW10: return CNT_W'(GRP_RAW10);
      default:    return CNT_W'(GRP_RAW12);
    endcase
  endfunction

  // Modes for which no data is accepted.
  function automatic logic mode_reserved(input raw_mode_e m);
`ifdef RAW_DECODER_RAW12_EN
    return (m == MODE_RSVD);
`else
    return (m == MODE_RSVD) || (m == MODE_RAW12);
`endif
  endfunction

endpackage

// File: rtl/raw_pixel_unpack.sv
// Combinational group-to-pixel mapping for RAW8/RAW10/RAW12.
// Ports:
//   mode_i  : pixel format of the group
//   grp_i   : group bytes, byte k at bits [8k+7:8k]
//   pix_c_o : four zero-extended pixels, pixel 1 in the LSB slot
module raw_pixel_unpack
  import csirx_raw_pkg::*;
#(
  parameter int unsigned PIX_W = 16
) (
  input  raw_mode_e                mode_i,
  input  logic [8*MAX_GRP-1:0]     grp_i,
  output logic [4*PIX_W-1:0]       pix_c_o
);

  logic [7:0] b [MAX_GRP];

  // Split the packed group into bytes.
  always_comb begin
    for (int unsigned k = 0; k < MAX_GRP; k++) begin
      b[k] = grp_i[8*k +: 8];
    end
  end

  // Byte-to-pixel placement; low bits come from the shared LSB byte(s).
  always_comb begin
    pix_c_o = '0;
    case (mode_i)
      MODE_RAW8: begin
        for (int k = 0; k < 4; k++) begin
          pix_c_o[k*PIX_W +: PIX_W] = PIX_W'(b[k]);
        end
      end
      MODE_RAW10: begin
        for (int k = 0; k < 4; k++) begin
          pix_c_o[k*PIX_W +: PIX_W] = PIX_W'({b[k], b[4][2*k +: 2]});
        end
      end
      MODE_RAW12: begin
        pix_c_o[0*PIX_W +: PIX_W] = PIX_W'({b[0], b[2][3:0]});
        pix_c_o[1*PIX_W +: PIX_W] = PIX_W'({b[1], b[2][7:4]});
        pix_c_o[2*PIX_W +: PIX_W] = PIX_W'({b[3], b[5][3:0]});
        pix_c_o[3*PIX_W +: PIX_W] = PIX_W'({b[4], b[5][7:4]});
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/raw_decoder.sv
// CSI-2 RX RAW8/RAW10/RAW12 decoder: accumulates received bytes and emits
// registered 4-pixel groups.
// Feature macro: RAW_DECODER_RAW12_EN enables RAW12 (mode 10); otherwise mode 10 is reserved.
// Ports:
//   rxbyteclkhs  : byte clock
//   reset_n      : synchronous active-low reset
//   frame_active : payload in progress
//   frame_valid  : frame in progress (valid = frame_active & frame_valid)
//   mode         : 00 RAW8, 01 RAW10, 10 RAW12, 11 reserved; latched at frame start
//   data_in      : IN_BYTES received bytes, first byte in the MSBs
//   data_out     : four pixels, pixel 1 in the LSB slot
//   out_valid    : data_out holds a complete group
//   frame_err    : one-cycle pulse on partial-group discard or reserved mode
module raw_decoder
  import csirx_raw_pkg::*;
#(
  parameter int unsigned IN_BYTES = 2,
  parameter int unsigned PIX_W    = 16
) (
  input  logic                  rxbyteclkhs,
  input  logic                  reset_n,
  input  logic                  frame_active,
  input  logic                  frame_valid,
  input  logic [1:0]            mode,
  input  logic [8*IN_BYTES-1:0] data_in,
  output logic [4*PIX_W-1:0]    data_out,
  output logic                  out_valid,
  output logic                  frame_err
);

  localparam int unsigned ACC_W = 8 * ACC_BYTES;
  localparam int unsigned IN_W  = 8 * IN_BYTES;
  localparam int unsigned GRP_W = 8 * MAX_GRP;

  logic                 valid_q, valid_d;
  raw_mode_e            mode_q, mode_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [4*PIX_W-1:0]   data_out_q, data_out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 frame_err_q, frame_err_d;

  logic                 valid_c, start_c, rsvd_c;
  raw_mode_e            cur_mode_c;
  logic [CNT_W-1:0]     grp_c, fill_c;
  logic [IN_W-1:0]      in_le_c;
  logic [ACC_W-1:0]     merged_c;
  logic [4*PIX_W-1:0]   pix_c;

  assign valid_c = frame_active & frame_valid;

  // Reorder input so the first received byte sits in the lowest byte lane.
  always_comb begin
    in_le_c = '0;
    for (int unsigned b = 0; b < IN_BYTES; b++) begin
      in_le_c[8*b +: 8] = data_in[8*(IN_BYTES-1-b) +: 8];
    end
  end

  // On the first valid cycle the incoming mode applies immediately.
  always_comb begin
    start_c    = valid_c & ~valid_q;
    cur_mode_c = start_c ? raw_mode_e'(mode) : mode_q;
    rsvd_c     = mode_reserved(cur_mode_c);
    grp_c      = group_size(cur_mode_c);
    fill_c     = cnt_q + CNT_W'(IN_BYTES);
    // Bytes above cnt_q are always zero, so OR-in appends in order.
    merged_c   = acc_q | (ACC_W'(in_le_c) << {cnt_q, 3'b000});
  end

  raw_pixel_unpack #(
    .PIX_W (PIX_W)
  ) u_unpack (
    .mode_i  (cur_mode_c),
    .grp_i   (merged_c[GRP_W-1:0]),
    .pix_c_o (pix_c)
  );

  // Next-state: accept, emit at most one group, flush on valid fall.
  always_comb begin
    valid_d     = valid_c;
    mode_d      = mode_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    data_out_d  = '0;
    out_valid_d = 1'b0;
    frame_err_d = 1'b0;

    if (start_c) begin
      mode_d = cur_mode_c;
    end

    if (valid_c) begin
      if (rsvd_c) begin
        frame_err_d = start_c;
      end else if (fill_c >= grp_c) begin
        out_valid_d = 1'b1;
        data_out_d  = pix_c;
        acc_d       = merged_c >> {grp_c, 3'b000};
        cnt_d       = fill_c - grp_c;
      end else begin
        acc_d = merged_c;
        cnt_d = fill_c;
      end
    end else if (valid_q) begin
      acc_d       = '0;
      cnt_d       = '0;
      frame_err_d = (cnt_q != '0);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge rxbyteclkhs) begin
    if (!reset_n) begin
      valid_q     <= 1'b0;
      mode_q      <= MODE_RAW8;
      acc_q       <= '0;
      cnt_q       <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;

endmodule
